border_detect_stream: RTL and testbench
=======================================

BORDER_DETECT_STREAM -- requirements
Module: border_detect_stream

Interface
REQ-001 Parameter WIDTH, default 320, pixels per row (>=3).
REQ-002 Parameter HEIGHT, default 240, rows per frame (>=3).
REQ-003 Parameter PIX_W, default 8, bits per pixel.
REQ-004 Parameter THRESH, default 127, binarisation threshold.
REQ-005 clk  input  1  single clock, all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mode  input  1  0 = inner border, 1 = outer border; sampled on first accepted pixel of each frame.
REQ-008 in_valid  input  1  input pixel valid.
REQ-009 in_ready  output  1  block accepts input pixel this cycle.
REQ-010 in_data  input  PIX_W  input pixel, raster order, row 0 col 0 first.
REQ-011 out_valid  output  1  output pixel valid.
REQ-012 out_ready  input  1  downstream accepts output pixel.
REQ-013 out_data  output  PIX_W  processed pixel.
REQ-014 out_last  output  1  marks pixel (HEIGHT-1, WIDTH-1) of the output frame.

Function
REQ-015 Transfer occurs on valid&&ready; the output side is a single register stage; in_ready = (out_ready || !out_valid) && state != FLUSH.
REQ-016 out_valid, out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-017 Column counter 0..WIDTH-1 and row counter 0..HEIGHT-1 advance per accepted input; column wraps to 0 and row increments; at (HEIGHT-1, WIDTH-1) both wrap to 0.
REQ-018 Two line delays plus a 3x3 window register provide neighbourhood of centre (r,c) once input (r+1,c+1) is accepted.
REQ-019 Background neighbour: value < THRESH; foreground centre: value > THRESH; value == THRESH is neither.
REQ-020 Mode 0: out = centre if centre foreground and any of 8 neighbours background, else 0.
REQ-021 Mode 1: out = all-ones (2^PIX_W-1) if centre < THRESH and any neighbour > THRESH, else 0.
REQ-022 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) SHALL output 0 in both modes.
REQ-023 Output order is raster order, exactly WIDTH*HEIGHT outputs per frame; output (r,c) is loaded into the output register on the cycle input index r*WIDTH+c+WIDTH+1 is accepted (one-cycle latency after that handshake).
REQ-024 Outputs for the first WIDTH+1 accepted inputs of a frame are not generated (FILL); row 0 and (1,0) outputs are produced as zeros starting with input index WIDTH+1.
REQ-025 States: IDLE (no frame in progress) -> FILL on first accepted pixel -> RUN after WIDTH+1 accepted pixels -> FLUSH after pixel (HEIGHT-1, WIDTH-1) accepted -> IDLE after final output handshake.
REQ-026 FLUSH emits the remaining WIDTH+1 outputs, all zero, one per cycle gated by out_ready, without input.
REQ-027 out_last asserted only with output (HEIGHT-1, WIDTH-1); mode latched for a frame applies to all its outputs.
REQ-028 Back-to-back frames: next frame starts only from IDLE; no input accepted during FLUSH.
REQ-029 Stall in any state freezes counters, window and line delays.

Reset
REQ-030 On reset: state IDLE, counters 0, out_valid 0, out_data 0, out_last 0, latched mode 0; in_ready 1 in the cycle after reset deasserts.
REQ-031 Reset mid-frame SHALL abandon the frame; line-buffer contents need not be cleared since FILL re-primes them.

Structure
REQ-032 Package border_pkg holds state enum (IDLE, FILL, RUN, FLUSH), mode enum (INNER, OUTER), default WIDTH/HEIGHT/PIX_W/THRESH constants.
REQ-033 One sub-module bd_line_buffer: WIDTH-deep, PIX_W-wide delay with enable, instantiated twice.

Verification (WIDTH=5, HEIGHT=4, PIX_W=8, THRESH=127 unless stated)
REQ-034 All-200 frame, mode 0, out_ready=1 -> 20 outputs all 0; out_last on 20th; state returns to IDLE.
REQ-035 All-200 except (1,1)=0, mode 0 -> outputs 200 at (1,2),(2,1),(2,2); all else 0; (1,1)=0.
REQ-036 All-0 except (2,2)=200, mode 1 -> 255 at (1,1),(1,2),(1,3),(2,1),(2,3); (2,2) and border positions 0.
REQ-037 Centre 127 with neighbour 0, mode 0 -> out 0; neighbour 127 with centre 200 -> out 0.
REQ-038 Random out_ready (50%) and in_valid gaps -> output sequence identical to REQ-035 run; no output changes while stalled.
REQ-039 Reset asserted after 7 accepted pixels, then full REQ-035 frame -> exact REQ-035 outputs, no stale data.

Source files
------------

// File: rtl/border_pkg.sv
// Shared types and default geometry for the streaming border detector.
// Frame-control states, border-mode encoding and parameter defaults.
package border_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    typedef enum logic {
        INNER,
        OUTER
    } mode_t;

    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_THRESH = 127;

endpackage

// File: rtl/bd_line_buffer.sv
// One image row of delay: dout is the sample written WIDTH enables earlier.
// Latency: WIDTH enabled cycles; output is combinational from the last stage.
// Backpressure: en low freezes every stage, so stalls never lose or skew pixels.
module bd_line_buffer #(
    parameter int WIDTH = 320,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem_q [WIDTH];
    logic [PIX_W-1:0] mem_d [WIDTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < WIDTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // No reset: stale contents only ever feed border outputs, which are forced to zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[WIDTH-1];

endmodule

// File: rtl/border_detect_stream.sv
// Streaming 3x3 inner/outer border detector over a binarised raster frame.
// Latency: output (r,c) registered on the accept of input (r+1,c+1); WIDTH+1 trailing outputs flushed.
// Backpressure: single output register; input stalls whenever it is full and not draining, and in FLUSH.
module border_detect_stream
    import border_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0]    COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0]    ROW_MAX = RW'(HEIGHT - 1);
    localparam logic [PIX_W-1:0] TH      = PIX_W'(THRESH);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CW-1:0]    in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0]    in_row_q, in_row_d, out_row_q, out_row_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [PIX_W-1:0] lb0_dout, lb1_dout, pix_res;
    logic             in_fire, out_fire, out_load, in_at_last, out_at_last;
    logic             border, nb_bg, nb_fg, centre_fg, centre_bg;

    assign in_ready    = (out_ready || !out_valid_q) && (state_q != FLUSH);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid_q && out_ready;
    assign in_at_last  = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
    assign out_at_last = (out_row_q == ROW_MAX) && (out_col_q == COL_MAX);

    bd_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb0 (
        .clk (clk), .en (in_fire), .din (in_data),  .dout (lb0_dout)
    );
    bd_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk (clk), .en (in_fire), .din (lb0_dout), .dout (lb1_dout)
    );

    // Row 0 of the window is the oldest line; column 2 is the incoming column.
    always_comb begin
        win_d = win_q;
        if (in_fire) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_dout;
            win_d[1][2] = lb0_dout;
            win_d[2][2] = in_data;
        end
    end

    always_comb begin
        nb_bg = 1'b0;
        nb_fg = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1)) begin
                    nb_bg |= (win_d[r][c] < TH);
                    nb_fg |= (win_d[r][c] > TH);
                end
            end
        end
        centre_fg = win_d[1][1] > TH;
        centre_bg = win_d[1][1] < TH;
        border    = (out_row_q == '0) || (out_row_q == ROW_MAX) ||
                    (out_col_q == '0) || (out_col_q == COL_MAX);
        pix_res   = '0;
        if (!border) begin
            if (mode_q == INNER) begin
                if (centre_fg && nb_bg) pix_res = win_d[1][1];
            end else begin
                if (centre_bg && nb_fg) pix_res = '1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = FILL;
                    mode_d  = mode_t'(mode);
                end
            end
            FILL: begin
                if (in_fire && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
            end
            RUN: begin
                if (in_fire) begin
                    out_load = 1'b1;
                    if (in_at_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The frame is done once the out_last beat itself has been taken.
                if (out_fire && out_last_q) begin
                    state_d = IDLE;
                end else if ((out_ready || !out_valid_q) && !(out_valid_q && out_last_q)) begin
                    out_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_fire) begin
            in_col_d = (in_col_q == COL_MAX) ? '0 : in_col_q + CW'(1);
            if (in_col_q == COL_MAX) in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + RW'(1);
        end

        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = pix_res;
            out_last_d  = out_at_last;
            out_col_d   = (out_col_q == COL_MAX) ? '0 : out_col_q + CW'(1);
            if (out_col_q == COL_MAX) out_row_d = (out_row_q == ROW_MAX) ? '0 : out_row_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= INNER;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_border_detect_stream.sv
// Directed frames on a 5x4 image with hand-computed expected outputs.
module tb_border_detect_stream;

    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset, mode, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_data, out_data;

    always #5 clk = ~clk;

    border_detect_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .THRESH(127)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] pix      [N];
    logic [7:0] exp_dat  [N];
    logic [7:0] got_dat  [N];
    logic       got_last [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_img(input logic [7:0] bg);
        for (int i = 0; i < N; i++) begin
            pix[i]     = bg;
            exp_dat[i] = 8'd0;
        end
    endtask

    // All 200 with a single 0 at (1,1): inner border at (1,2),(2,1),(2,2).
    task automatic setup_hole();
        fill_img(8'd200);
        pix[6]      = 8'd0;
        exp_dat[7]  = 8'd200;
        exp_dat[11] = 8'd200;
        exp_dat[12] = 8'd200;
    endtask

    task automatic run_frame(input string name, input logic md, input bit rnd);
        int         in_idx = 0;
        int         nout = 0;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_dat = 8'd0;
        logic       prev_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            got_dat[i]  = 8'hxx;
            got_last[i] = 1'bx;
        end
        while (nout < N && cyc < 1000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk({name, ":hold_vld"},  32'(out_valid), 32'd1);
                chk({name, ":hold_dat"},  32'(out_data),  32'(prev_dat));
                chk({name, ":hold_last"}, 32'(out_last),  32'(prev_last));
            end
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (in_idx < N) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = pix[in_idx];
                mode     = (in_idx == 0) ? md : ~md;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_idx >= N) chk({name, ":flush_rdy"}, 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (nout <= N - W - 2)
                    chk($sformatf("%s:lat%0d", name, nout), 32'(in_idx), 32'(nout + W + 2));
                got_dat[nout]  = out_data;
                got_last[nout] = out_last;
                nout++;
            end
            if (in_valid && in_ready) in_idx++;
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
            cyc++;
        end
        chk({name, ":count"}, 32'(nout), 32'(N));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s:dat%0d", name, i),  32'(got_dat[i]),  32'(exp_dat[i]));
            chk($sformatf("%s:last%0d", name, i), 32'(got_last[i]), 32'(i == N - 1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({name, ":idle_rdy"}, 32'(in_ready),  32'd1);
        chk({name, ":idle_vld"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst:vld",  32'(out_valid), 32'd0);
        chk("rst:dat",  32'(out_data),  32'd0);
        chk("rst:last", 32'(out_last),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst:rdy", 32'(in_ready), 32'd1);

        fill_img(8'd200);
        run_frame("allfg", 1'b0, 1'b0);

        setup_hole();
        run_frame("hole", 1'b0, 1'b0);

        fill_img(8'd0);
        pix[12]     = 8'd200;
        exp_dat[6]  = 8'd255;
        exp_dat[7]  = 8'd255;
        exp_dat[8]  = 8'd255;
        exp_dat[11] = 8'd255;
        exp_dat[13] = 8'd255;
        run_frame("outer", 1'b1, 1'b0);

        fill_img(8'd200);
        pix[6] = 8'd127;
        run_frame("thr_nb", 1'b0, 1'b0);

        fill_img(8'd200);
        pix[6]      = 8'd127;
        pix[12]     = 8'd0;
        exp_dat[7]  = 8'd200;
        exp_dat[8]  = 8'd200;
        exp_dat[11] = 8'd200;
        exp_dat[13] = 8'd200;
        run_frame("thr_ctr", 1'b0, 1'b0);

        setup_hole();
        run_frame("stall", 1'b0, 1'b1);

        // Abandon a partial outer-mode frame with reset, then a clean frame.
        fill_img(8'd0);
        pix[3] = 8'd200;
        k   = 0;
        cyc = 0;
        while (k < 7 && cyc < 100) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = pix[k];
            out_ready = 1'b1;
            mode      = 1'b1;
            #1;
            if (in_ready) k++;
            cyc++;
        end
        chk("mid:fed", 32'(k), 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid:rdy",  32'(in_ready),  32'd1);
        chk("mid:vld",  32'(out_valid), 32'd0);
        chk("mid:dat",  32'(out_data),  32'd0);
        chk("mid:last", 32'(out_last),  32'd0);

        setup_hole();
        run_frame("rst_hole", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
